// File: rtl/kyber_ser_pkg.sv
// Shared definitions for the Kyber result serializer: mode codes, FSM state, header magic and word counts.
// The header word feature is selected in the top by the KYBER_SER_HDR_EN macro.
package kyber_ser_pkg;

    localparam logic [1:0] MODE_KEYGEN = 2'd0;
    localparam logic [1:0] MODE_ENC    = 2'd1;
    localparam logic [1:0] MODE_DEC    = 2'd2;
    localparam logic [1:0] MODE_RSVD   = 2'd3;

    localparam logic [15:0] HDR_MAGIC = 16'h4B59;

    localparam int PK_BITS_DEF  = 6400;
    localparam int SK_BITS_DEF  = 6144;
    localparam int CT_BITS_DEF  = 6144;
    localparam int MSG_BITS_DEF = 256;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } ser_state_t;

    // Payload words per result; the reserved mode carries nothing.
    function automatic logic [15:0] nwords(
        input logic [1:0] mode,
        input int         w,
        input int         pk_bits  = PK_BITS_DEF,
        input int         sk_bits  = SK_BITS_DEF,
        input int         ct_bits  = CT_BITS_DEF,
        input int         msg_bits = MSG_BITS_DEF
    );
        case (mode)
            MODE_KEYGEN: return 16'((pk_bits + sk_bits) / w);
            MODE_ENC:    return 16'(ct_bits / w);
            MODE_DEC:    return 16'(msg_bits / w);
            default:     return 16'd0;
        endcase
    endfunction

endpackage

// File: rtl/kyber_ser_shift.sv
// Load / shift-right-by-W holding register for the captured result; the low word is the next beat.
module kyber_ser_shift #(
    parameter int WIDTH = 12544,
    parameter int W     = 32
) (
    input  logic             clk,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-1:0] load_data,
    output logic [W-1:0]     word
);

    logic [WIDTH-1:0] sr;

    // Pure datapath: contents are only observed while o_valid is set, so no reset is needed.
    always_ff @(posedge clk) begin
        if (load) begin
            sr <= load_data;
        end else if (shift) begin
            sr <= sr >> W;
        end
    end

    assign word = sr[W-1:0];

endmodule

// File: rtl/kyber_out_serializer.sv
// Captures Kyber core results on finish and streams them LS word first over valid/ready.
// Define KYBER_SER_HDR_EN to prefix every result with a header word.
//
// state   | meaning
// --------+--------------------------------------------------------------
// ST_IDLE | no result held; waiting for finish with a valid mode
// ST_SEND | streaming header (optional) and payload words to the host
module kyber_out_serializer
    import kyber_ser_pkg::*;
#(
    parameter int W        = 32,
    parameter int PK_BITS  = PK_BITS_DEF,
    parameter int SK_BITS  = SK_BITS_DEF,
    parameter int CT_BITS  = CT_BITS_DEF,
    parameter int MSG_BITS = MSG_BITS_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                finish,
    input  logic [1:0]          mode,
    input  logic [PK_BITS-1:0]  pk_in,
    input  logic [SK_BITS-1:0]  sk_in,
    input  logic [CT_BITS-1:0]  c_in,
    input  logic [MSG_BITS-1:0] m_in,
    output logic                o_valid,
    input  logic                i_ready,
    output logic [W-1:0]        o_data,
    output logic                o_last,
    output logic                busy,
    output logic                done,
    output logic                ovf
);

    localparam int SR_W = PK_BITS + SK_BITS;

`ifdef KYBER_SER_HDR_EN
    localparam bit HDR_EN = 1'b1;
`else
    localparam bit HDR_EN = 1'b0;
`endif

    ser_state_t  state;
    logic [15:0] remaining;
    logic        hdr_phase;
    logic [31:0] hdr_word;

    logic            cap_ok;
    logic            xfer;
    logic            last_xfer;
    logic            take;
    logic [15:0]     n_cap;
    logic [SR_W-1:0] load_data;
    logic [W-1:0]    sh_word;

    assign cap_ok    = finish && (mode != MODE_RSVD);
    assign xfer      = o_valid && i_ready;
    assign last_xfer = xfer && !hdr_phase && (remaining == 16'd1);
    // A finish landing on the final handshake chains straight into the next result.
    assign take      = cap_ok && ((state == ST_IDLE) || last_xfer);
    assign n_cap     = nwords(mode, W, PK_BITS, SK_BITS, CT_BITS, MSG_BITS);

    always_comb begin
        load_data = '0;
        case (mode)
            MODE_KEYGEN: load_data = {sk_in, pk_in};
            MODE_ENC:    load_data = SR_W'(c_in);
            MODE_DEC:    load_data = SR_W'(m_in);
            default:     load_data = '0;
        endcase
    end

    kyber_ser_shift #(
        .WIDTH (SR_W),
        .W     (W)
    ) u_shift (
        .clk       (clk),
        .load      (take),
        .shift     (xfer && !hdr_phase),
        .load_data (load_data),
        .word      (sh_word)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_IDLE;
            remaining <= '0;
            hdr_phase <= 1'b0;
            hdr_word  <= '0;
            o_valid   <= 1'b0;
            o_last    <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            ovf       <= 1'b0;
        end else begin
            done <= 1'b0;
            if (cap_ok && !take && (state == ST_SEND)) begin
                ovf <= 1'b1;
            end
            if (take) begin
                state     <= ST_SEND;
                o_valid   <= 1'b1;
                busy      <= 1'b1;
                remaining <= n_cap;
                hdr_phase <= HDR_EN;
                hdr_word  <= {HDR_MAGIC, 5'b0, mode, n_cap[8:0]};
                o_last    <= (HDR_EN == 1'b0) && (n_cap == 16'd1);
                if (last_xfer) begin
                    done <= 1'b1;
                end
            end else if ((state == ST_SEND) && xfer) begin
                if (hdr_phase) begin
                    hdr_phase <= 1'b0;
                    o_last    <= (remaining == 16'd1);
                end else if (remaining == 16'd1) begin
                    state     <= ST_IDLE;
                    remaining <= '0;
                    o_valid   <= 1'b0;
                    o_last    <= 1'b0;
                    busy      <= 1'b0;
                    done      <= 1'b1;
                end else begin
                    remaining <= remaining - 16'd1;
                    o_last    <= (remaining == 16'd2);
                end
            end
        end
    end

    assign o_data = !o_valid  ? '0 :
                    hdr_phase ? W'(hdr_word) : sh_word;

endmodule
